// File: rtl/ssg_pkg.sv
// Shared seven-segment constants, converter state encoding and decode helpers
// for the score scan controller.
package ssg_pkg;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [7:0] ANODE_OFF = 8'hFF;

  typedef enum logic [1:0] {
    CONV_IDLE = 2'd0,
    CONV_RUN  = 2'd1,
    CONV_DONE = 2'd2
  } conv_state_e;

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ssg_bin2bcd.sv
// Iterative double-dabble converter: one shift-add-3 step per cycle for
// SCORE_W cycles; the BCD output only changes when a conversion completes.
module ssg_bin2bcd
  import ssg_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int SCORE_W = 14
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [SCORE_W-1:0]     bin,
  output logic                   busy,
  output logic                   done,
  output logic [DIGITS-1:0][3:0] bcd
);

  localparam int CNT_W = $clog2(SCORE_W + 1);
  localparam int SH_W  = 4 * DIGITS + SCORE_W;

  conv_state_e            state, state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [SCORE_W-1:0]     sh_bin, nxt_bin;
  logic [DIGITS-1:0][3:0] sh_bcd, adj_bcd, nxt_bcd;
  logic [SH_W-1:0]        sh_all;
  logic                   accept;
  logic                   last;

  assign accept = start && (state != CONV_RUN);
  assign last   = (cnt == CNT_W'(SCORE_W - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= CONV_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CONV_IDLE: if (start) state_nxt = CONV_RUN;
      CONV_RUN:  if (last)  state_nxt = CONV_DONE;
      CONV_DONE: state_nxt = start ? CONV_RUN : CONV_IDLE;
      default:   state_nxt = CONV_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CONV_RUN);
    done = (state == CONV_DONE);
  end

  // One dabble step: bump every nibble >= 5 by 3, then shift the whole chain
  always_comb begin
    adj_bcd = sh_bcd;
    for (int i = 0; i < DIGITS; i++)
      if (sh_bcd[i] >= 4'd5) adj_bcd[i] = sh_bcd[i] + 4'd3;
    sh_all  = {adj_bcd, sh_bin} << 1;
    nxt_bcd = sh_all[SH_W-1:SCORE_W];
    nxt_bin = sh_all[SCORE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      sh_bin <= '0;
      sh_bcd <= '0;
      bcd    <= '0;
    end else if (accept) begin
      cnt    <= '0;
      sh_bin <= bin;
      sh_bcd <= '0;
    end else if (state == CONV_RUN) begin
      cnt    <= cnt + 1'b1;
      sh_bin <= nxt_bin;
      sh_bcd <= nxt_bcd;
      if (last) bcd <= nxt_bcd;
    end
  end

endmodule

// File: rtl/ssg_scan_control.sv
// Score display controller: saturating load, BCD conversion and multiplexed
// seven-segment scanning. Define SSG_BLANK_EN to blank leading-zero digits.
module ssg_scan_control
  import ssg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int SCORE_W     = 14,
  parameter int REFRESH_DIV = 100000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SCORE_W-1:0] SSG_scan_score,
  input  logic               SSG_scan_load,
  output logic               SSG_scan_busy,
  output logic               SSG_scan_done,
  output logic [7:0]         SSG_scan_anode,
  output logic [6:0]         SSG_scan_cathodes
);

  localparam int          IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int          PRE_W   = $clog2(REFRESH_DIV);
  localparam int unsigned MAX_VAL = pow10(DIGITS) - 1;

  logic [SCORE_W-1:0]     score_sat;
  logic [DIGITS-1:0][3:0] disp;
  logic [PRE_W-1:0]       pre_cnt;
  logic [IDX_W-1:0]       idx;
  logic                   pre_wrap;
  logic [3:0]             cur_digit;
  logic                   cur_blank;
  logic [DIGITS-1:0]      lead_blank;
  logic [7:0]             anode_nxt;
  logic [6:0]             cath_nxt;

  // Clamp to the largest value the digit count can show
  always_comb begin
    score_sat = SSG_scan_score;
    if (32'(SSG_scan_score) > MAX_VAL) score_sat = SCORE_W'(MAX_VAL);
  end

  ssg_bin2bcd #(
    .DIGITS (DIGITS),
    .SCORE_W(SCORE_W)
  ) u_bin2bcd (
    .clk  (clk),
    .reset(reset),
    .start(SSG_scan_load),
    .bin  (score_sat),
    .busy (SSG_scan_busy),
    .done (SSG_scan_done),
    .bcd  (disp)
  );

  assign pre_wrap = (pre_cnt == PRE_W'(REFRESH_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt <= '0;
      idx     <= '0;
    end else begin
      pre_cnt <= pre_wrap ? '0 : pre_cnt + 1'b1;
      if (pre_wrap) idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  always_comb begin
    lead_blank = '0;
`ifdef SSG_BLANK_EN
    // Digit i blanks when it and every digit above it are zero; digit 0 never blanks
    begin
      logic above_zero;
      above_zero = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
        above_zero    = above_zero && (disp[i] == 4'd0);
        lead_blank[i] = above_zero;
      end
    end
`else
    lead_blank = '0;
`endif
  end

  always_comb begin
    cur_digit = '0;
    cur_blank = 1'b0;
    anode_nxt = ANODE_OFF;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_digit    = disp[i];
        cur_blank    = lead_blank[i];
        anode_nxt[i] = 1'b0;
      end
    end
    cath_nxt = cur_blank ? SEG_BLANK : seg_decode(cur_digit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      SSG_scan_anode    <= ANODE_OFF;
      SSG_scan_cathodes <= SEG_BLANK;
    end else begin
      SSG_scan_anode    <= anode_nxt;
      SSG_scan_cathodes <= cath_nxt;
    end
  end

endmodule

// File: tb/tb_ssg_scan_control.sv
// Directed bench for ssg_scan_control with a fast refresh divider.
module tb_ssg_scan_control;

  localparam int DIGITS      = 4;
  localparam int SCORE_W     = 14;
  localparam int REFRESH_DIV = 4;

  localparam logic [6:0] P0 = 7'b1000000;
  localparam logic [6:0] P1 = 7'b1111001;
  localparam logic [6:0] P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000;
  localparam logic [6:0] P4 = 7'b0011001;
  localparam logic [6:0] P5 = 7'b0010010;
  localparam logic [6:0] P7 = 7'b1111000;
  localparam logic [6:0] P9 = 7'b0010000;
`ifdef SSG_BLANK_EN
  localparam logic [6:0] LZ = 7'b1111111;
`else
  localparam logic [6:0] LZ = 7'b1000000;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [SCORE_W-1:0] score = '0;
  logic               load = 1'b0;
  logic               busy, done;
  logic [7:0]         anode;
  logic [6:0]         cath;

  int checks = 0;
  int passed = 0;
  logic [6:0] cap [4];

  ssg_scan_control #(
    .DIGITS     (DIGITS),
    .SCORE_W    (SCORE_W),
    .REFRESH_DIV(REFRESH_DIV)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .SSG_scan_score   (score),
    .SSG_scan_load    (load),
    .SSG_scan_busy    (busy),
    .SSG_scan_done    (done),
    .SSG_scan_anode   (anode),
    .SSG_scan_cathodes(cath)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int anode_digit(input logic [7:0] a);
    case (a)
      8'hFE:   return 0;
      8'hFD:   return 1;
      8'hFB:   return 2;
      8'hF7:   return 3;
      default: return -1;
    endcase
  endfunction

  // Records the cathode pattern seen on each strobed digit over a full scan
  task automatic capture();
    int d;
    for (int i = 0; i < 4; i++) cap[i] = 'x;
    repeat (20) begin
      d = anode_digit(anode);
      if (d >= 0) cap[d] = cath;
      tick();
    end
  endtask

  // Issues a load, optionally a second load at sample second_at, and watches 40 cycles
  task automatic run_conv(input logic [SCORE_W-1:0] v, input int second_at,
                          input logic [SCORE_W-1:0] v2, input logic [3:0][6:0] old,
                          output int bcnt, output int dcnt, output int dpos,
                          output int glitch);
    int d;
    score = v;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    bcnt = 0; dcnt = 0; dpos = -1; glitch = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) begin
        bcnt++;
        d = anode_digit(anode);
        if (d >= 0 && cath !== old[d]) glitch++;
      end
      if (done) begin
        dcnt++;
        if (dpos < 0) dpos = i;
      end
      load = (i == second_at);
      if (i == second_at) score = v2;
      tick();
    end
    load = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] seq [5];
    seq[0] = 8'hFE; seq[1] = 8'hFD; seq[2] = 8'hFB; seq[3] = 8'hF7; seq[4] = 8'hFE;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (anode !== 8'hFF || cath !== 7'h7F || busy !== 1'b0 || done !== 1'b0)
        $display("FAIL reset_hold[%0d]: anode=%h cath=%b busy=%b done=%b, want FF 1111111 0 0",
                 i, anode, cath, busy, done);
      else passed++;
    end
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 0) begin
        checks++;
        if (cath !== P0) $display("FAIL first_digit_cath: got %b want %b", cath, P0);
        else passed++;
      end
      checks++;
      if (anode !== seq[k/4]) $display("FAIL scan_anode[%0d]: got %h want %h", k, anode, seq[k/4]);
      else passed++;
    end
  endtask

  task automatic test_convert();
    int bcnt, dcnt, dpos, glitch;
    run_conv(14'd1234, -1, '0, {LZ, LZ, LZ, P0}, bcnt, dcnt, dpos, glitch);
    checks++;
    if (bcnt !== 14) $display("FAIL conv_busy_len: got %0d want 14", bcnt); else passed++;
    checks++;
    if (dcnt !== 1 || dpos !== 14)
      $display("FAIL conv_done: count %0d at %0d, want 1 at 14", dcnt, dpos);
    else passed++;
    checks++;
    if (glitch !== 0) $display("FAIL conv_hold_display: %0d changed samples, want 0", glitch);
    else passed++;
    capture();
    checks++;
    if (cap[0] !== P4 || cap[1] !== P3 || cap[2] !== P2 || cap[3] !== P1)
      $display("FAIL disp_1234: got %b %b %b %b want %b %b %b %b",
               cap[0], cap[1], cap[2], cap[3], P4, P3, P2, P1);
    else passed++;
  endtask

  task automatic test_saturate();
    int bcnt, dcnt, dpos, glitch;
    run_conv(14'd12000, -1, '0, {P1, P2, P3, P4}, bcnt, dcnt, dpos, glitch);
    checks++;
    if (dcnt !== 1) $display("FAIL sat_done: got %0d want 1", dcnt); else passed++;
    checks++;
    if (glitch !== 0) $display("FAIL sat_hold_display: %0d changed samples, want 0", glitch);
    else passed++;
    capture();
    checks++;
    if (cap[0] !== P9 || cap[1] !== P9 || cap[2] !== P9 || cap[3] !== P9)
      $display("FAIL disp_9999: got %b %b %b %b want all %b", cap[0], cap[1], cap[2], cap[3], P9);
    else passed++;
  endtask

  task automatic test_load_while_busy();
    int bcnt, dcnt, dpos, glitch;
    run_conv(14'd5, 2, 14'd7, {P9, P9, P9, P9}, bcnt, dcnt, dpos, glitch);
    checks++;
    if (bcnt !== 14) $display("FAIL busy_ignore_len: got %0d want 14", bcnt); else passed++;
    checks++;
    if (dcnt !== 1) $display("FAIL busy_ignore_done: got %0d want 1", dcnt); else passed++;
    capture();
    checks++;
    if (cap[0] !== P5 || cap[1] !== LZ || cap[2] !== LZ || cap[3] !== LZ)
      $display("FAIL disp_5: got %b %b %b %b want %b %b %b %b",
               cap[0], cap[1], cap[2], cap[3], P5, LZ, LZ, LZ);
    else passed++;
  endtask

  task automatic test_leading_zero();
    int bcnt, dcnt, dpos, glitch;
    run_conv(14'd7, -1, '0, {LZ, LZ, LZ, P5}, bcnt, dcnt, dpos, glitch);
    checks++;
    if (dcnt !== 1) $display("FAIL lz_done: got %0d want 1", dcnt); else passed++;
    capture();
    checks++;
    if (cap[0] !== P7) $display("FAIL lz_digit0: got %b want %b", cap[0], P7); else passed++;
    checks++;
    if (cap[1] !== LZ || cap[2] !== LZ || cap[3] !== LZ)
      $display("FAIL lz_upper: got %b %b %b want %b", cap[1], cap[2], cap[3], LZ);
    else passed++;
  endtask

  task automatic test_reset_mid_conv();
    int dcnt;
    score = 14'd99;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (busy !== 1'b1) $display("FAIL mid_busy: got %b want 1", busy); else passed++;
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || anode !== 8'hFF)
      $display("FAIL mid_reset: busy=%b done=%b anode=%h want 0 0 FF", busy, done, anode);
    else passed++;
    tick();
    reset = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (done || busy) dcnt++;
      tick();
    end
    checks++;
    if (dcnt !== 0) $display("FAIL mid_no_done: got %0d busy/done cycles want 0", dcnt);
    else passed++;
    capture();
    checks++;
    if (cap[0] !== P0 || cap[1] !== LZ || cap[2] !== LZ || cap[3] !== LZ)
      $display("FAIL mid_disp_0: got %b %b %b %b want %b %b %b %b",
               cap[0], cap[1], cap[2], cap[3], P0, LZ, LZ, LZ);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_convert();
    test_saturate();
    test_load_while_busy();
    test_leading_zero();
    test_reset_mid_conv();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ssg_scan_control.md
SSG_SCAN_CONTROL -- requirements
Module: ssg_scan_control

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of scanned digits (1..8).
REQ-002 SHALL have parameter SCORE_W, default 14, score input width (4..27).
REQ-003 SHALL have parameter REFRESH_DIV, default 100000, clk cycles per digit slot (>=2).
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port SSG_scan_score  in  SCORE_W  unsigned binary score.
REQ-007 SHALL have port SSG_scan_load  in  1  request to capture SSG_scan_score.
REQ-008 SHALL have port SSG_scan_busy  out  1  conversion in progress.
REQ-009 SHALL have port SSG_scan_done  out  1  one-cycle pulse when new value is displayed.
REQ-010 SHALL have port SSG_scan_anode  out  8  active-low one-hot digit enable.
REQ-011 SHALL have port SSG_scan_cathodes  out  7  active-low segments, bit order {g,f,e,d,c,b,a}.

Function
REQ-012 SHALL accept a load only when SSG_scan_load=1 and busy=0; a load while busy=1 SHALL be ignored, with no queuing.
REQ-013 SHALL, on accept, saturate any score greater than 10^DIGITS-1 to 10^DIGITS-1 before conversion.
REQ-014 SHALL convert with iterative shift-add-3 (double dabble); busy SHALL be high starting the cycle after accept, for exactly SCORE_W cycles.
REQ-015 SHALL, on the edge where busy falls, update the display BCD register atomically and pulse done for exactly that one cycle.
REQ-016 SHALL keep the displayed value unchanged during conversion, with no partial BCD shown.
REQ-017 SHALL use a prescaler that counts 0..REFRESH_DIV-1 and wraps.
REQ-018 SHALL advance the digit index when the prescaler wraps; the index SHALL wrap from DIGITS-1 to 0.
REQ-019 SHALL register anode and cathodes outputs, which follow the digit index with 1-cycle latency.
REQ-020 SHALL drive anode bit i low only when index==i; bits DIGITS..7 SHALL always be 1.
REQ-021 SHALL encode cathodes as 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111.
REQ-022 SHALL let load/conversion and scanning run independently; a display update that coincides with an index change SHALL show the new value on the new digit.

Reset
REQ-023 SHALL, with reset high, clear prescaler, index, display register (value 0), busy, done and conversion state; anode=8'hFF and cathodes=7'h7F while reset is high.
REQ-024 SHALL show digit 0 with the value-0 pattern the first cycle after reset deasserts (anode=~1, cathodes=1000000).
REQ-025 SHALL, on reset mid-conversion, abort the conversion with no done pulse, and displayed value SHALL be 0.

Configuration
REQ-026 SHALL, with macro SSG_BLANK_EN defined, drive cathodes to the blank pattern for leading-zero digits above the most significant non-zero digit, while digit 0 is always shown and the anode still strobes.
REQ-027 SHALL, with SSG_BLANK_EN undefined, display all DIGITS digits including leading zeros.

Structure
REQ-028 SHALL place segment constants SEG_0..SEG_9, SEG_BLANK and ANODE_OFF in shared package ssg_pkg.
REQ-029 SHALL implement the double-dabble engine as sub-module ssg_bin2bcd (start/busy/done, BCD out); the scan, decode and blanking logic SHALL remain in the top module.

Verification (bench uses REFRESH_DIV=4, DIGITS=4, SCORE_W=14)
REQ-030 SHALL cover: hold reset 3 cycles, then release -> FF/7F during reset; next cycle anode FE, cathodes 1000000; index steps every 4 cycles, anode FE,FD,FB,F7,FE.
REQ-031 SHALL cover: load 1234 -> busy 14 cycles, one done pulse; then anode FE/FD/FB/F7 shows 0011001/0110000/0100100/1111001.
REQ-032 SHALL cover: load 12000 -> saturated; all four digits show 0010000 (9999).
REQ-033 SHALL cover: load 5, then load 7 three cycles later -> second load ignored, 5 displayed, exactly one done pulse.
REQ-034 SHALL cover: load 7 -> with SSG_BLANK_EN, digit0 shows 1111000 and digits 1-3 show 1111111; without the macro, digits 1-3 show 1000000.
REQ-035 SHALL cover: load 99, then assert reset at conversion cycle 6 -> busy 0, no done pulse, display shows 0.
